// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter family.
package axis_arb_pkg;

  // Arbiter lock state: IDLE looks for a winner, LOCK forwards one packet.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Width of a source index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr, searching upward and wrapping at NUM-1.
module rr_pick #(
  parameter int unsigned NUM = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [NUM-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [IDW:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_id = '0;
    idx    = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IDW + 1)'(i);
      if (idx >= (IDW + 1)'(NUM)) begin
        idx = idx - (IDW + 1)'(NUM);
      end
      if (req[idx[IDW-1:0]]) begin
        gnt_id = idx[IDW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-stream sink between NUM
// sources. A grant is held from the first beat to the tlast handshake, so
// packets never interleave. An idle cycle separates consecutive packets,
// which keeps the sink datapath a pure mux off registered state.
module axis_rr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM       = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned USIZE     = 1,
  parameter int unsigned MAX_BEATS = 256,
  localparam int unsigned IDW      = id_width(NUM)
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM-1:0]       s_tvalid,
  output logic [NUM-1:0]       s_tready,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM*USIZE-1:0] s_tuser,
  input  logic [NUM-1:0]       s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DSIZE-1:0]     m_tdata,
  output logic [USIZE-1:0]     m_tuser,
  output logic                 m_tlast,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 err_overlen
);

  // Counter reaches MAX_BEATS and then saturates there.
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_WARN = CW'(MAX_BEATS - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BEATS);

  arb_state_e     state_q;
  logic [IDW-1:0] ptr_q;
  logic [CW-1:0]  beat_cnt_q;
  logic           err_q;

  logic [IDW-1:0] pick_id;
  logic           pick_any;
  logic           hs;

  rr_pick #(
    .NUM (NUM),
    .IDW (IDW)
  ) u_pick (
    .req    (s_tvalid),
    .ptr    (ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign hs          = m_tvalid & m_tready;
  assign busy        = (state_q == LOCK);
  assign err_overlen = err_q;

  // Lock FSM: grant on any request while enabled, release on tlast handshake.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_id <= '0;
    end else if (state_q == IDLE) begin
      if (enable && pick_any) begin
        state_q  <= LOCK;
        grant_id <= pick_id;
        ptr_q    <= (pick_id == IDW'(NUM - 1)) ? '0 : pick_id + 1'b1;
      end
    end else if (hs && m_tlast) begin
      state_q <= IDLE;
    end
  end

  // Overlength watchdog: one pulse when the MAX_BEATS-th beat is not last.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q != LOCK) begin
        beat_cnt_q <= '0;
      end else if (hs) begin
        if (m_tlast) begin
          beat_cnt_q <= '0;
        end else begin
          if (beat_cnt_q == CNT_WARN) begin
            err_q <= 1'b1;
          end
          if (beat_cnt_q != CNT_MAX) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Sink mux and ready steering; everything is held at zero outside LOCK.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tuser  = '0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == LOCK) begin
      m_tvalid           = s_tvalid[grant_id];
      m_tdata            = s_tdata[int'(grant_id) * DSIZE +: DSIZE];
      m_tuser            = s_tuser[int'(grant_id) * USIZE +: USIZE];
      m_tlast            = s_tlast[grant_id];
      s_tready[grant_id] = m_tready;
    end
  end

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Randomized bench for axis_rr_pkt_arbiter with a packet-level reference model.
module tb_axis_rr_pkt_arbiter;

  localparam int unsigned NUM       = 4;
  localparam int unsigned DSIZE     = 8;
  localparam int unsigned USIZE     = 2;
  localparam int unsigned MAX_BEATS = 8;
  localparam int unsigned IDW       = 2;

  logic                 clock    = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 enable   = 1'b0;
  logic [NUM-1:0]       s_tvalid = '0;
  logic [NUM-1:0]       s_tready;
  logic [NUM*DSIZE-1:0] s_tdata  = '0;
  logic [NUM*USIZE-1:0] s_tuser  = '0;
  logic [NUM-1:0]       s_tlast  = '0;
  logic                 m_tvalid;
  logic                 m_tready = 1'b0;
  logic [DSIZE-1:0]     m_tdata;
  logic [USIZE-1:0]     m_tuser;
  logic                 m_tlast;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err_overlen;

  axis_rr_pkt_arbiter #(
    .NUM       (NUM),
    .DSIZE     (DSIZE),
    .USIZE     (USIZE),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .enable      (enable),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tuser     (s_tuser),
    .s_tlast     (s_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_overlen (err_overlen)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which packet owns the sink and where the search resumes.
  bit mbusy;
  int mgrant;
  int mptr;
  bit merr;

  // Producers: current packet length (0 = none) and 0-based beat index.
  int src_len  [NUM];
  int src_beat [NUM];
  bit src_hs   [NUM];

  // Stimulus knobs for the current phase.
  logic [NUM-1:0] knob_mask;
  int knob_rate, knob_lo, knob_hi, knob_gap, knob_rdy, knob_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int rr_next(input logic [NUM-1:0] req, input int from);
    for (int k = 0; k < NUM; k++) begin
      if (req[(from + k) % NUM]) return (from + k) % NUM;
    end
    return -1;
  endfunction

  task automatic set_knobs(input logic [NUM-1:0] mask, input int rate, input int lo,
                           input int hi, input int gap, input int rdy, input int en);
    knob_mask = mask;
    knob_rate = rate;
    knob_lo   = lo;
    knob_hi   = hi;
    knob_gap  = gap;
    knob_rdy  = rdy;
    knob_en   = en;
  endtask

  // Called at a falling edge: retire accepted beats, raise new ones.
  task automatic drive();
    for (int i = 0; i < NUM; i++) begin
      if (src_hs[i]) begin
        s_tvalid[i] = 1'b0;
        src_hs[i]   = 1'b0;
      end
      if (!s_tvalid[i]) begin
        if (src_len[i] == 0 && knob_mask[i] && $urandom_range(99) < knob_rate) begin
          src_len[i]  = $urandom_range(knob_hi, knob_lo);
          src_beat[i] = 0;
        end
        if (src_len[i] != 0 && $urandom_range(99) >= knob_gap) begin
          s_tvalid[i]                  = 1'b1;
          s_tdata[i*DSIZE +: DSIZE]    = DSIZE'($urandom);
          s_tuser[i*USIZE +: USIZE]    = USIZE'($urandom);
          s_tlast[i]                   = (src_beat[i] == src_len[i] - 1);
        end
      end
    end
    m_tready = ($urandom_range(99) < knob_rdy);
    enable   = (knob_en == 2) ? 1'($urandom_range(1)) : (knob_en == 1);
  endtask

  // One clock: check registered state, drive, check sink, advance the model.
  task automatic cycle();
    logic [NUM-1:0] exp_rdy;
    bit hs;
    int g;
    int w;
    chk("busy", 32'(busy), 32'(mbusy));
    chk("grant_id", 32'(grant_id), 32'(mgrant));
    chk("err_overlen", 32'(err_overlen), 32'(merr));
    drive();
    #1;
    g       = mgrant;
    exp_rdy = '0;
    if (mbusy && m_tready) exp_rdy[g] = 1'b1;
    chk("m_tvalid", 32'(m_tvalid), mbusy ? 32'(s_tvalid[g]) : 32'd0);
    chk("s_tready", 32'(s_tready), 32'(exp_rdy));
    chk("m_tdata", 32'(m_tdata), mbusy ? 32'(s_tdata[g*DSIZE +: DSIZE]) : 32'd0);
    chk("m_tuser", 32'(m_tuser), mbusy ? 32'(s_tuser[g*USIZE +: USIZE]) : 32'd0);
    chk("m_tlast", 32'(m_tlast), mbusy ? 32'(s_tlast[g]) : 32'd0);
    hs   = mbusy && s_tvalid[g] && m_tready;
    merr = hs && !s_tlast[g] && (src_beat[g] + 1 == MAX_BEATS);
    if (hs) begin
      src_hs[g] = 1'b1;
      if (s_tlast[g]) begin
        src_len[g] = 0;
        mbusy      = 1'b0;
      end else begin
        src_beat[g]++;
      end
    end else if (!mbusy && enable && (|s_tvalid)) begin
      w      = rr_next(s_tvalid, mptr);
      mbusy  = 1'b1;
      mgrant = w;
      mptr   = (w + 1) % NUM;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  // Asynchronous reset in the middle of a packet; producers restart packets.
  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_err", 32'(err_overlen), 32'd0);
    mbusy  = 1'b0;
    mgrant = 0;
    mptr   = 0;
    merr   = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      src_beat[i] = 0;
      src_hs[i]   = 1'b0;
      s_tvalid[i] = 1'b0;
    end
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NUM; i++) begin
      src_len[i]  = 0;
      src_beat[i] = 0;
      src_hs[i]   = 1'b0;
    end
    mbusy  = 1'b0;
    mgrant = 0;
    mptr   = 0;
    merr   = 1'b0;
    set_knobs('1, 100, 3, 3, 0, 100, 1);

    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    chk("reset_err", 32'(err_overlen), 32'd0);
    chk("reset_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("reset_s_tready", 32'(s_tready), 32'd0);
    chk("reset_m_tdata", 32'(m_tdata), 32'd0);
    rst_n = 1'b1;

    // Fairness: every source streams 3-beat packets, sink always ready.
    run(64);
    // Mixed traffic with backpressure and producer gaps.
    set_knobs('1, 50, 1, 5, 25, 60, 1);
    run(300);
    // Arbitration off: in-flight packets drain, then nothing is granted.
    set_knobs('1, 100, 1, 5, 0, 100, 0);
    run(40);
    // Enable toggling randomly, including mid-packet.
    set_knobs('1, 50, 1, 6, 20, 70, 2);
    run(300);
    // Overlength packets from source 0, then from everyone.
    set_knobs(4'b0001, 100, 9, 12, 10, 80, 1);
    run(150);
    set_knobs('1, 40, 1, 12, 20, 60, 1);
    run(300);
    // Lone requester on the highest index: pointer wraps, no lockup.
    set_knobs(4'b1000, 100, 1, 3, 0, 100, 1);
    run(100);
    // Reset while a packet is partly transferred.
    set_knobs('1, 100, 4, 8, 0, 50, 1);
    guard = 0;
    while (!(mbusy && src_beat[mgrant] >= 1) && guard < 100) begin
      cycle();
      guard++;
    end
    chk("mid_packet_busy", 32'(busy), 32'd1);
    reset_mid();
    set_knobs('1, 50, 1, 6, 20, 60, 1);
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
